// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter: screen geometry,
// coordinate/colour types and the frame-event decode.
package sprite_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // First pixel of vertical blanking: the only safe point to retarget the sprite
    function automatic logic frame_event(input coord_t x, input coord_t y);
        return (x == 10'd0) && (y == 10'(V_ACTIVE));
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Control-side bundle of the sprite blitter: position update handshake
// and animation enable.
interface sprite_blitter_if;
    import sprite_pkg::*;

    coord_t pos_x;
    coord_t pos_y;
    logic   pos_valid;
    logic   pos_ready;
    logic   anim_en;

    modport master (output pos_x, output pos_y, output pos_valid, output anim_en,
                    input  pos_ready);
    modport slave  (input  pos_x, input  pos_y, input  pos_valid, input  anim_en,
                    output pos_ready);

endinterface

// File: rtl/sprite_anim_ctrl.sv
// Position double-buffer (pending -> active at frame events) and the
// animation divider / frame index counter.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter  int FRAMES   = 4,
    parameter  int ANIM_DIV = 8,
    localparam int FIDX_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    sprite_blitter_if.slave   pos_bus,
    input  logic              frame_ev,
    output coord_t            act_x,
    output coord_t            act_y,
    output logic [FIDX_W-1:0] frame_idx
);

    coord_t            act_x_r;
    coord_t            act_y_r;
    coord_t            pend_x_r;
    coord_t            pend_y_r;
    logic              pend_r;
    logic              ready_r;
    logic [DIV_W-1:0]  div_r;
    logic [FIDX_W-1:0] frame_r;

    // Position handshake: a pending update is only promoted at a frame event,
    // so the active position is stable for a whole displayed frame.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            act_x_r  <= 10'd0;
            act_y_r  <= 10'd0;
            pend_x_r <= 10'd0;
            pend_y_r <= 10'd0;
            pend_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else if (frame_ev && pend_r) begin
            act_x_r <= pend_x_r;
            act_y_r <= pend_y_r;
            pend_r  <= 1'b0;
            ready_r <= 1'b1;
        end else if (pos_bus.pos_valid && ready_r) begin
            pend_x_r <= pos_bus.pos_x;
            pend_y_r <= pos_bus.pos_y;
            pend_r   <= 1'b1;
            ready_r  <= 1'b0;
        end else begin
            pend_r  <= pend_r;
            ready_r <= ready_r;
        end
    end

    // Animation stepping: divider counts enabled frame events, frame index wraps
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            div_r   <= {DIV_W{1'b0}};
            frame_r <= {FIDX_W{1'b0}};
        end else if (frame_ev && pos_bus.anim_en) begin
            if (div_r == DIV_W'(ANIM_DIV - 1)) begin
                div_r   <= {DIV_W{1'b0}};
                frame_r <= (frame_r == FIDX_W'(FRAMES - 1)) ? {FIDX_W{1'b0}}
                                                            : frame_r + FIDX_W'(1);
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end else begin
            div_r   <= div_r;
            frame_r <= frame_r;
        end
    end

    assign act_x             = act_x_r;
    assign act_y             = act_y_r;
    assign frame_idx         = frame_r;
    assign pos_bus.pos_ready = ready_r;

endmodule

// File: rtl/sprite_blitter.sv
// Single animated, integer-scaled sprite layer: hit test, ROM address
// generation, latency-matched flag pipeline and registered RGB/hit output.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 20,
    parameter int SPR_H      = 20,
    parameter int FRAMES     = 4,
    parameter int SCALE_LOG2 = 1,
    parameter int ROM_LAT    = 1,
    parameter int IDX_W      = 5,
    parameter int ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES),
    parameter int TRANSP_IDX = 0,
    parameter int ANIM_DIV   = 8
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  logic              blank,
    sprite_blitter_if.slave   pos_bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              pixel_hit
);

    localparam int FIDX_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam int BOX_W    = SPR_W << SCALE_LOG2;
    localparam int BOX_H    = SPR_H << SCALE_LOG2;

    coord_t              act_x_s;
    coord_t              act_y_s;
    logic [FIDX_W-1:0]   frame_idx_s;
    logic                frame_ev_s;
    logic [10:0]         lx_s;
    logic [10:0]         ly_s;
    logic [10:0]         u_s;
    logic [10:0]         v_s;
    logic                in_x_s;
    logic                in_y_s;
    logic                in_box_s;
    logic [ADDR_W-1:0]   addr_s;

    logic [ADDR_W-1:0]   rom_addr_r;
    logic [ROM_LAT:0]    inbox_pipe_r;
    logic [ROM_LAT:0]    blank_pipe_r;
    rgb12_t              rgb_r;
    logic                hit_r;

    assign frame_ev_s = frame_event(DrawX, DrawY);

    sprite_anim_ctrl #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV)
    ) u_anim_ctrl (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .pos_bus   (pos_bus),
        .frame_ev  (frame_ev_s),
        .act_x     (act_x_s),
        .act_y     (act_y_s),
        .frame_idx (frame_idx_s)
    );

    // Hit test in 11 bits so the box end past column 1023 never wraps
    always_comb begin
        lx_s     = {1'b0, DrawX} - {1'b0, act_x_s};
        ly_s     = {1'b0, DrawY} - {1'b0, act_y_s};
        u_s      = lx_s >> SCALE_LOG2;
        v_s      = ly_s >> SCALE_LOG2;
        in_x_s   = ({1'b0, DrawX} >= {1'b0, act_x_s}) &&
                   ({1'b0, DrawX} <  ({1'b0, act_x_s} + 11'(BOX_W)));
        in_y_s   = ({1'b0, DrawY} >= {1'b0, act_y_s}) &&
                   ({1'b0, DrawY} <  ({1'b0, act_y_s} + 11'(BOX_H)));
        in_box_s = in_x_s && in_y_s;
        if (in_box_s) begin
            addr_s = ADDR_W'(int'(frame_idx_s) * FRAME_SZ + int'(v_s) * SPR_W + int'(u_s));
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    // Address register plus flag delay line matched to the ROM latency
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_addr_r   <= {ADDR_W{1'b0}};
            inbox_pipe_r <= {(ROM_LAT + 1){1'b0}};
            blank_pipe_r <= {(ROM_LAT + 1){1'b0}};
        end else begin
            rom_addr_r   <= addr_s;
            inbox_pipe_r <= {inbox_pipe_r[ROM_LAT-1:0], in_box_s};
            blank_pipe_r <= {blank_pipe_r[ROM_LAT-1:0], blank};
        end
    end

    // Output stage: opaque texel inside active video drives palette colour
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rgb_r <= 12'd0;
            hit_r <= 1'b0;
        end else if (blank_pipe_r[ROM_LAT] && inbox_pipe_r[ROM_LAT] &&
                     (rom_q != IDX_W'(TRANSP_IDX))) begin
            rgb_r <= rgb12_t'(pal_rgb);
            hit_r <= 1'b1;
        end else begin
            rgb_r <= 12'd0;
            hit_r <= 1'b0;
        end
    end

    assign rom_addr  = rom_addr_r;
    assign pal_index = rom_q;
    assign red       = rgb_r.r;
    assign green     = rgb_r.g;
    assign blue      = rgb_r.b;
    assign pixel_hit = hit_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed scenarios plus random
// pixels, scored against a coordinate-level model of the sprite layer.
module tb_sprite_blitter;
    import sprite_pkg::*;

    localparam int SPR_W    = 20;
    localparam int SPR_H    = 20;
    localparam int FRAMES   = 4;
    localparam int SCALE    = 2;
    localparam int ANIM_DIV = 8;
    localparam int TRANSP   = 0;
    localparam int ADDR_W   = 11;

    logic              vga_clk = 1'b0;
    logic              reset;
    coord_t            DrawX;
    coord_t            DrawY;
    logic              blank;
    logic [ADDR_W-1:0] rom_addr;
    logic [4:0]        rom_q;
    logic [4:0]        pal_index;
    logic [11:0]       pal_rgb;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              pixel_hit;

    sprite_blitter_if bus ();

    logic [4:0]  rom_mem [0:SPR_W*SPR_H*FRAMES-1];
    logic [11:0] pal_mem [0:31];

    int compared   = 0;
    int mismatched = 0;

    // Reference state: positions, pending request, enabled frame-event count
    int          m_ax, m_ay, m_px, m_py, m_anim;
    bit          m_pend;
    logic [12:0] hist [$];

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];
    assign pal_rgb = pal_mem[pal_index];

    sprite_blitter dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .pos_bus   (bus.slave),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .pal_index (pal_index),
        .pal_rgb   (pal_rgb),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .pixel_hit (pixel_hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_anim = 0; m_pend = 1'b0;
        hist.delete();
    endtask

    // One pixel clock: drive inputs, predict, clock, then score
    task automatic step(input int x, input int y, input bit b, input bit pv);
        int          ea, fr, idx;
        bit          inb, fe;
        logic [12:0] ep;
        DrawX         = coord_t'(x);
        DrawY         = coord_t'(y);
        blank         = b;
        bus.pos_valid = pv;
        fr  = (m_anim / ANIM_DIV) % FRAMES;
        inb = (x >= m_ax) && (x < m_ax + SPR_W*SCALE) && (y >= m_ay) && (y < m_ay + SPR_H*SCALE);
        ea  = inb ? fr*SPR_W*SPR_H + ((y - m_ay)/SCALE)*SPR_W + (x - m_ax)/SCALE : 0;
        idx = int'(rom_mem[ea]);
        ep  = (b && inb && idx != TRANSP) ? {1'b1, pal_mem[idx]} : 13'd0;
        hist.push_back(ep);
        fe = (x == 0) && (y == 480);
        if (fe && m_pend) begin
            m_ax = m_px; m_ay = m_py; m_pend = 1'b0;
        end else if (pv && !m_pend) begin
            m_px = int'(bus.pos_x); m_py = int'(bus.pos_y); m_pend = 1'b1;
        end
        if (fe && bus.anim_en) m_anim++;
        @(posedge vga_clk);
        #1;
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        chk("pos_ready", 32'(bus.pos_ready), 32'(!m_pend));
        if (hist.size() > 2) ep = hist.pop_front();
        else ep = 13'd0;
        chk("pixel", {19'd0, pixel_hit, red, green, blue}, {19'd0, ep});
        bus.pos_valid = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
        chk("rst_hit", 32'(pixel_hit), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_ready", 32'(bus.pos_ready), 32'd1);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic move_to(input int px, input int py);
        bus.pos_x = coord_t'(px);
        bus.pos_y = coord_t'(py);
        step(300, 300, 1'b0, 1'b1);
        step(0, 480, 1'b0, 1'b0);
    endtask

    initial begin
        int x, y;
        reset = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
        bus.pos_x = 10'd0; bus.pos_y = 10'd0; bus.pos_valid = 1'b0; bus.anim_en = 1'b0;
        for (int i = 0; i < SPR_W*SPR_H*FRAMES; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        for (int i = 0; i < 32; i++) pal_mem[i] = 12'($urandom_range(1, 4095));
        rom_mem[21] = 5'd5;
        rom_mem[22] = 5'd0;
        pal_mem[5]  = 12'hF80;
        pal_mem[0]  = 12'hFFF;
        model_clear();
        do_reset();

        // Basic draw at (100,50): texel (1,1) -> address 21
        bus.pos_x = 10'd100; bus.pos_y = 10'd50;
        step(10, 10, 1'b1, 1'b1);
        step(0, 480, 1'b0, 1'b0);
        step(103, 53, 1'b1, 1'b0);
        chk("t2_addr", 32'(rom_addr), 32'd21);
        step(104, 53, 1'b1, 1'b0);
        step(140, 53, 1'b1, 1'b0);
        chk("t2_rgb", {19'd0, pixel_hit, red, green, blue}, 32'h1F80);
        step(103, 53, 1'b0, 1'b0);
        step(103, 53, 1'b1, 1'b0);
        chk("t3_transp", {19'd0, pixel_hit, red, green, blue}, 32'd0);
        step(5, 5, 1'b1, 1'b0);
        chk("t3_blank", {19'd0, pixel_hit, red, green, blue}, 32'd0);
        step(5, 5, 1'b1, 1'b0);
        chk("t1_pre", {19'd0, pixel_hit, red, green, blue}, 32'h1F80);
        do_reset();

        // Deferred position update takes effect only at the frame event
        move_to(100, 50);
        bus.pos_x = 10'd200; bus.pos_y = 10'd200;
        step(30, 100, 1'b1, 1'b1);
        step(110, 60, 1'b1, 1'b0);
        step(150, 89, 1'b1, 1'b0);
        step(210, 210, 1'b1, 1'b0);
        step(0, 480, 1'b0, 1'b0);
        step(200, 200, 1'b1, 1'b0);
        step(239, 239, 1'b1, 1'b0);

        // Animation: 8 events -> frame 1, 32 -> wrap, 12 then freeze -> frame 1
        bus.anim_en = 1'b1;
        repeat (8) step(0, 480, 1'b0, 1'b0);
        step(200, 200, 1'b1, 1'b0);
        chk("t5_f1", 32'(rom_addr), 32'd400);
        repeat (24) step(0, 480, 1'b0, 1'b0);
        step(200, 200, 1'b1, 1'b0);
        chk("t5_wrap", 32'(rom_addr), 32'd0);
        repeat (12) step(0, 480, 1'b0, 1'b0);
        bus.anim_en = 1'b0;
        repeat (5) step(0, 480, 1'b0, 1'b0);
        step(200, 200, 1'b1, 1'b0);
        chk("t5_hold", 32'(rom_addr), 32'd400);

        // Random pixels, occasional frame events and position requests
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 49) == 0) bus.anim_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                step(0, 480, 1'b0, 1'b0);
            end else begin
                x = m_ax + int'($urandom_range(0, 59)) - 10;
                y = m_ay + int'($urandom_range(0, 59)) - 10;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                bus.pos_x = coord_t'($urandom_range(0, 600));
                bus.pos_y = coord_t'($urandom_range(0, 440));
                step(x, y, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
            end
        end
        bus.anim_en = 1'b0;

        // Right-edge clipping at x=630: no wrap into columns 0..29
        do_reset();
        move_to(630, 0);
        for (int i = 620; i < 640; i++) begin
            step(i, 0, 1'b1, 1'b0);
            if (i == 634) chk("t6_addr", 32'(rom_addr), 32'd2);
        end
        for (int i = 0; i < 30; i++) step(i, 0, 1'b1, 1'b0);
        step(300, 300, 1'b1, 1'b0);
        step(300, 300, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
